// File: rtl/mux_2to1_pkg.sv
// Shared constants and helpers for the mux_2to1 block.
// Holds the default data width and the select-transition counter
// width and saturation value.
package mux_2to1_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned SEL_CNT_W      = 16;
    localparam logic [SEL_CNT_W-1:0] SEL_CNT_MAX = {SEL_CNT_W{1'b1}};

    // Saturating increment for the select-transition counter.
    function automatic logic [SEL_CNT_W-1:0] sat_inc(input logic [SEL_CNT_W-1:0] cnt);
        logic [SEL_CNT_W-1:0] nxt;
        if (cnt == SEL_CNT_MAX) begin
            nxt = cnt;
        end else begin
            nxt = cnt + {{(SEL_CNT_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mux_2to1_comb.sv
// Parameterised purely combinational 2:1 select.
// Output follows v when selm=0 and w when selm=1, with no clock or
// reset involvement, so it can drive same-cycle index/address paths.
module mux_2to1_comb
    import mux_2to1_pkg::*;
#(
    parameter int unsigned k = DATA_W_DEFAULT
) (
    input  logic [k-1:0] v,
    input  logic [k-1:0] w,
    input  logic         selm,
    output logic [k-1:0] f
);

    // Select between the two data inputs.
    always_comb begin
        f = v;
        if (selm) begin
            f = w;
        end else begin
            f = v;
        end
    end

endmodule

// File: rtl/mux_2to1.sv
// 2:1 multiplexer with an optional registered copy of the result.
// F is the zero-latency select; Fq/Fq_vld are a load-enabled register
// stage with synchronous active-low reset.
// Optional feature: define MUX_2TO1_SELCNT_EN to build a saturating
// count of Selm transitions on SelCnt; otherwise SelCnt is tied to 0
// and no counter or select flops exist.
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int unsigned k = DATA_W_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [k-1:0]         V,
    input  logic [k-1:0]         W,
    input  logic                 Selm,
    input  logic                 En,
    output logic [k-1:0]         F,
    output logic [k-1:0]         Fq,
    output logic                 Fq_vld,
    output logic [SEL_CNT_W-1:0] SelCnt
);

    logic [k-1:0] f_s;
    logic [k-1:0] fq_r;
    logic         fq_vld_r;

    mux_2to1_comb #(
        .k (k)
    ) u_comb (
        .v    (V),
        .w    (W),
        .selm (Selm),
        .f    (f_s)
    );

    assign F      = f_s;
    assign Fq     = fq_r;
    assign Fq_vld = fq_vld_r;

    // Result register: reset wins over load; valid is sticky until reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            fq_r     <= {k{1'b0}};
            fq_vld_r <= 1'b0;
        end else if (En) begin
            fq_r     <= f_s;
            fq_vld_r <= 1'b1;
        end else begin
            fq_r     <= fq_r;
            fq_vld_r <= fq_vld_r;
        end
    end

`ifdef MUX_2TO1_SELCNT_EN
    logic                 selm_r;
    logic [SEL_CNT_W-1:0] sel_cnt_r;

    // Track previous select and count edges where it changed (saturating).
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            selm_r    <= 1'b0;
            sel_cnt_r <= {SEL_CNT_W{1'b0}};
        end else begin
            selm_r <= Selm;
            if (Selm != selm_r) begin
                sel_cnt_r <= sat_inc(sel_cnt_r);
            end else begin
                sel_cnt_r <= sel_cnt_r;
            end
        end
    end

    assign SelCnt = sel_cnt_r;
`else
    assign SelCnt = {SEL_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: directed corner cases plus
// randomized traffic compared against a behavioural model.
module tb_mux_2to1;
    import mux_2to1_pkg::*;

`ifdef MUX_2TO1_SELCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        rst_n;
    logic        en;
    logic        sel;
    logic [31:0] v;
    logic [31:0] w;
    logic [31:0] f;
    logic [31:0] fq;
    logic        fq_vld;
    logic [15:0] sel_cnt;

    // 5-bit instance signals (clock never toggles)
    logic        clk5 = 1'b0;
    logic        rst5_n = 1'b0;
    logic        en5 = 1'b0;
    logic        sel5;
    logic [4:0]  v5;
    logic [4:0]  w5;
    logic [4:0]  f5;
    logic [4:0]  fq5;
    logic        fq_vld5;
    logic [15:0] sel_cnt5;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_fq;
    logic        m_vld;
    int          m_trans;
    logic        m_prev;

    mux_2to1 #(.k(32)) dut (
        .Clk(clk), .Rst_n(rst_n), .V(v), .W(w), .Selm(sel), .En(en),
        .F(f), .Fq(fq), .Fq_vld(fq_vld), .SelCnt(sel_cnt)
    );

    mux_2to1 #(.k(5)) dut5 (
        .Clk(clk5), .Rst_n(rst5_n), .V(v5), .W(w5), .Selm(sel5), .En(en5),
        .F(f5), .Fq(fq5), .Fq_vld(fq_vld5), .SelCnt(sel_cnt5)
    );

    function automatic logic [15:0] exp_cnt();
        if (!CNT_ON) return 16'h0000;
        if (m_trans > 65535) return 16'hFFFF;
        return 16'(m_trans);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, update the model from pre-edge inputs, optionally check.
    task automatic step(input bit do_chk);
        @(posedge clk);
        if (!rst_n) begin
            m_fq    = 32'h0;
            m_vld   = 1'b0;
            m_trans = 0;
            m_prev  = 1'b0;
        end else begin
            if (en) begin
                m_fq  = sel ? w : v;
                m_vld = 1'b1;
            end
            if (sel != m_prev) m_trans++;
            m_prev = sel;
        end
        #1;
        if (do_chk) begin
            check("fq", {32'h0, fq}, {32'h0, m_fq});
            check("fq_vld", {63'h0, fq_vld}, {63'h0, m_vld});
            check("sel_cnt", {48'h0, sel_cnt}, {48'h0, exp_cnt()});
            check("f", {32'h0, f}, {32'h0, (sel ? w : v)});
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sel = 1'b0; v = 32'h0; w = 32'h0;
        v5 = 5'h03; w5 = 5'h1F; sel5 = 1'b0;
        m_fq = 32'h0; m_vld = 1'b0; m_trans = 0; m_prev = 1'b0;

        // Narrow instance, clock stopped: pure combinational select
        #1;
        check("k5_sel0", {59'h0, f5}, 64'h03);
        sel5 = 1'b1;
        #1;
        check("k5_sel1", {59'h0, f5}, 64'h1F);

        // Reset state
        rst_n = 1'b0; en = 1'b0;
        step(1'b1);
        check("rst_fq", {32'h0, fq}, 64'h0);
        check("rst_vld", {63'h0, fq_vld}, 64'h0);
        check("rst_cnt", {48'h0, sel_cnt}, 64'h0);

        // Load DEADBEEF
        rst_n = 1'b1; v = 32'hDEADBEEF; sel = 1'b0; en = 1'b1;
        step(1'b1);
        check("load_fq", {32'h0, fq}, 64'hDEADBEEF);
        check("load_vld", {63'h0, fq_vld}, 64'h1);

        // Hold with En=0 while F follows the new selection
        en = 1'b0; w = 32'h12345678; sel = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        check("hold_fq", {32'h0, fq}, 64'hDEADBEEF);
        check("hold_f", {32'h0, f}, 64'h12345678);

        // F still follows inputs during reset
        rst_n = 1'b0;
        #1;
        check("f_in_rst", {32'h0, f}, 64'h12345678);

        // Reset beats load
        en = 1'b1; v = 32'hFFFFFFFF; sel = 1'b0;
        step(1'b1);
        check("rst_win_fq", {32'h0, fq}, 64'h0);
        check("rst_win_vld", {63'h0, fq_vld}, 64'h0);

        // Five consecutive Selm toggles after reset
        rst_n = 1'b1; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel = ~sel;
            step(1'b1);
        end
        check("cnt5", {48'h0, sel_cnt}, CNT_ON ? 64'd5 : 64'd0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            v     = $urandom;
            w     = $urandom;
            sel   = 1'($urandom_range(0, 1));
            en    = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 19) != 0);
            #1;
            check("rnd_f", {32'h0, f}, {32'h0, (sel ? w : v)});
            step(1'b1);
        end

        // Saturation: force 70000 toggles
        rst_n = 1'b1; en = 1'b0;
        step(1'b1);
        for (int i = 0; i < 70000; i++) begin
            sel = ~sel;
            step(1'b0);
        end
        check("cnt_sat", {48'h0, sel_cnt}, CNT_ON ? 64'hFFFF : 64'h0);
        sel = ~sel;
        step(1'b1);
        check("cnt_sat_hold", {48'h0, sel_cnt}, CNT_ON ? 64'hFFFF : 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_2to1.md
MUX_2TO1 -- requirements
Module: mux_2to1

Interface
REQ-001 k, default 32, data width in bits, legal range 1..64.
REQ-002 Clk  input  1  single clock; all sequential logic on rising edge.
REQ-003 Rst_n  input  1  reset, synchronous and active-low.
REQ-004 V  input  k  data input selected when Selm=0.
REQ-005 W  input  k  data input selected when Selm=1.
REQ-006 Selm  input  1  select.
REQ-007 En  input  1  register-stage load enable.
REQ-008 F  output  k  combinational mux result.
REQ-009 Fq  output  k  registered mux result.
REQ-010 Fq_vld  output  1  Fq holds a value loaded since reset.
REQ-011 SelCnt  output  16  count of Selm transitions (see Configuration).

Function
REQ-012 F SHALL equal V when Selm=0 and W when Selm=1, with zero latency and no dependency on Clk or Rst_n.
REQ-013 F SHALL be a purely combinational function of V, W and Selm, so that the block is usable as a same-cycle address or register-index select, e.g. k=5 for a write-register index.
REQ-014 On a rising edge with Rst_n=1 and En=1, Fq SHALL load the current F value and Fq_vld SHALL become 1; load latency is 1 cycle.
REQ-015 On a rising edge with Rst_n=1 and En=0, Fq and Fq_vld SHALL hold their values.
REQ-016 Once set, Fq_vld SHALL stay 1 until the next reset.
REQ-017 If V, W and Selm all change in the same cycle that En=1, Fq SHALL capture the mux of the values present before the edge.
REQ-018 The width SHALL be exactly k bits on every data path, with no sign or zero extension inside the block.

Reset
REQ-019 When Rst_n=0 at a rising edge, Fq SHALL be set to all zeros, Fq_vld to 0 and SelCnt to 0, regardless of En.
REQ-020 Reset SHALL NOT affect F, which continues to follow its inputs during reset.
REQ-021 If reset is asserted in the same cycle as En=1, reset SHALL win.
REQ-022 The block SHALL contain no initial-value or file-load initialisation; reset is the only initialisation.

Configuration
REQ-023 Macro MUX_2TO1_SELCNT_EN controls the SelCnt feature.
REQ-024 With the macro defined, the block SHALL register Selm every cycle.
REQ-025 With the macro defined, SelCnt SHALL increment by 1 on each edge where Selm differs from its registered copy.
REQ-026 With the macro defined, SelCnt SHALL saturate at 16'hFFFF.
REQ-027 With the macro defined, the registered Selm copy SHALL reset to 0.
REQ-028 Without the macro, SelCnt SHALL be tied to 0, no counter or select flops SHALL exist, and all other behaviour is unchanged.

Structure
REQ-029 A shared package mux_2to1_pkg SHALL hold the SelCnt width constant (16) and its saturation value.
REQ-030 The default width constant (32) SHALL also live in mux_2to1_pkg.
REQ-031 One sub-module, mux_2to1_comb, is natural: the parameterised combinational select producing F.
REQ-032 mux_2to1 SHALL wrap mux_2to1_comb and add the register stage and counter.

Verification
REQ-033 k=5, V=5'h03, W=5'h1F: Selm=0 -> F=5'h03 immediately; Selm=1 -> F=5'h1F immediately, with Clk stopped.
REQ-034 k=32, Rst_n=0 for 1 edge -> Fq=0, Fq_vld=0, SelCnt=0; release, then V=32'hDEADBEEF, Selm=0, En=1 for 1 edge -> Fq=32'hDEADBEEF, Fq_vld=1.
REQ-035 After Fq=32'hDEADBEEF, set En=0, W=32'h12345678, Selm=1 for 3 edges -> Fq holds 32'hDEADBEEF while F=32'h12345678.
REQ-036 Rst_n=0 and En=1 together on one edge with V=32'hFFFFFFFF -> Fq=0, Fq_vld=0.
REQ-037 With MUX_2TO1_SELCNT_EN defined, toggle Selm on 5 consecutive edges -> SelCnt=5; force 70000 toggles -> SelCnt=16'hFFFF; with the macro undefined, the same stimulus -> SelCnt=0.
